// File: rtl/runner_char_if.sv
// Game-side bundle for the runner character: tick/control inputs toward the
// character and sprite geometry/state outputs toward the renderer.
interface runner_char_if #(
  parameter int SPEED_W = 5
);
  logic                update;
  logic [SPEED_W-1:0]  speed;
  logic                jump;
  logic                duck;
  logic                crash;
  logic signed [11:0]  x_pos;
  logic signed [11:0]  y_pos;
  logic [9:0]          width;
  logic [9:0]          height;
  logic [2:0]          state;
  logic [2:0]          frame;

  // Game/input side: drives the tick and controls, observes the sprite.
  modport master (
    output update, speed, jump, duck, crash,
    input  x_pos, y_pos, width, height, state, frame
  );

  // Character side: consumes the tick and controls, produces the sprite.
  modport slave (
    input  update, speed, jump, duck, crash,
    output x_pos, y_pos, width, height, state, frame
  );
endinterface

// File: rtl/runner_char.sv
// Endless-runner player character: jump physics with fractional gravity,
// speed-scaled take-off, duck/fast-drop, crash/restart and sprite animation.
module runner_char #(
  parameter int START_X       = 50,
  parameter int GROUND_Y      = 93,
  parameter int WIDTH         = 44,
  parameter int HEIGHT        = 47,
  parameter int WIDTH_DUCK    = 59,
  parameter int HEIGHT_DUCK   = 25,
  parameter int INIT_JUMP_VEL = -10,
  parameter int SPEED_SHIFT   = 3,
  parameter int GRAVITY_NUM   = 6,
  parameter int GRAVITY_DEN   = 10,
  parameter int MIN_JUMP_H    = 30,
  parameter int MAX_JUMP_Y    = 30,
  parameter int DROP_VEL      = -5,
  parameter int FAST_DROP_VEL = 12,
  parameter int RUN_PERIOD    = 5,
  parameter int BLINK_PERIOD  = 60,
  parameter int BLINK_LEN     = 6,
  parameter int SPEED_W       = 5
) (
  input logic         clk,
  input logic         rst,
  runner_char_if.slave bus
);

  typedef enum logic [2:0] {
    WAITING = 3'd0,
    RUNNING = 3'd1,
    JUMPING = 3'd2,
    DUCKING = 3'd3,
    CRASHED = 3'd4
  } state_t;

  localparam logic [2:0] F_WAIT0 = 3'd0;
  localparam logic [2:0] F_WAIT1 = 3'd1;
  localparam logic [2:0] F_RUN0  = 3'd2;
  localparam logic [2:0] F_RUN1  = 3'd3;
  localparam logic [2:0] F_JUMP0 = 3'd4;
  localparam logic [2:0] F_DUCK0 = 3'd5;
  localparam logic [2:0] F_DUCK1 = 3'd6;
  localparam logic [2:0] F_CRASH = 3'd7;

  localparam logic signed [11:0] GROUND_Y12 = 12'(GROUND_Y);
  localparam logic signed [12:0] GROUND_Y13 = 13'(GROUND_Y);
  localparam logic signed [11:0] MIN_H_Y    = 12'(GROUND_Y - MIN_JUMP_H);
  localparam logic signed [11:0] MAX_Y      = 12'(MAX_JUMP_Y);
  localparam logic signed [9:0]  V_INIT     = 10'(INIT_JUMP_VEL);
  localparam logic signed [9:0]  V_DROP     = 10'(DROP_VEL);
  localparam logic signed [9:0]  V_FAST     = 10'(FAST_DROP_VEL);
  localparam logic [5:0]         G_NUM      = 6'(GRAVITY_NUM);
  localparam logic [5:0]         G_DEN      = 6'(GRAVITY_DEN);
  localparam logic [7:0]         RUN_P      = 8'(RUN_PERIOD);
  localparam logic [7:0]         RUN_WRAP   = 8'(2 * RUN_PERIOD);
  localparam logic [7:0]         BLINK_WRAP = 8'(BLINK_PERIOD);
  localparam logic [7:0]         BLINK_ON   = 8'(BLINK_PERIOD - BLINK_LEN);

  state_t             state_reg, state_next;
  logic signed [11:0] y_reg, y_next;
  logic signed [9:0]  vel_reg, vel_next;
  logic [4:0]         acc_reg, acc_next;
  logic               min_reg, min_next;
  logic [7:0]         anim_reg, anim_next;
  logic               jump_q_reg, jump_q_next;
  logic [2:0]         frame_reg, frame_next;

  // Airborne arithmetic, evaluated every cycle from the current registers.
  logic [9:0]         speed_ext;
  logic signed [9:0]  vel_take;
  logic signed [12:0] y_sum;
  logic [5:0]         acc_sum;
  logic [4:0]         acc_grav;
  logic signed [9:0]  vel_grav;
  logic               min_set;
  logic               jump_edge;
  logic               in_play;
  logic [7:0]         anim_inc;

  assign speed_ext = {{(10 - SPEED_W){1'b0}}, bus.speed};
  assign vel_take  = V_INIT - $signed(speed_ext >> SPEED_SHIFT);
  assign y_sum     = $signed({y_reg[11], y_reg}) + $signed({{3{vel_reg[9]}}, vel_reg});
  assign acc_sum   = {1'b0, acc_reg} + G_NUM;
  assign acc_grav  = (acc_sum >= G_DEN) ? 5'(acc_sum - G_DEN) : acc_sum[4:0];
  assign vel_grav  = (acc_sum >= G_DEN) ? vel_reg + 10'sd1 : vel_reg;
  assign min_set   = min_reg | (y_reg <= MIN_H_Y);
  assign jump_edge = bus.jump & ~jump_q_reg;
  assign in_play   = (state_reg == RUNNING) || (state_reg == JUMPING) || (state_reg == DUCKING);
  assign anim_inc  = anim_reg + 8'd1;

  // Next-state logic: crash overrides everything, all else waits for a tick.
  always_comb begin
    state_next  = state_reg;
    y_next      = y_reg;
    vel_next    = vel_reg;
    acc_next    = acc_reg;
    min_next    = min_reg;
    jump_q_next = jump_q_reg;
    anim_next   = anim_reg;
    frame_next  = frame_reg;

    if (bus.crash && in_play) begin
      state_next = CRASHED;
    end else if (bus.update) begin
      jump_q_next = bus.jump;
      case (state_reg)
        WAITING: if (jump_edge) state_next = RUNNING;
        RUNNING: begin
          if (bus.jump) begin
            state_next = JUMPING;
            vel_next   = vel_take;
            acc_next   = 5'd0;
            min_next   = 1'b0;
          end else if (bus.duck) begin
            state_next = DUCKING;
          end
        end
        DUCKING: if (!bus.duck) state_next = RUNNING;
        JUMPING: begin
          if (y_sum >= GROUND_Y13) begin
            state_next = bus.duck ? DUCKING : RUNNING;
            y_next     = GROUND_Y12;
            vel_next   = 10'sd0;
            acc_next   = 5'd0;
          end else begin
            y_next   = y_sum[11:0];
            acc_next = acc_grav;
            min_next = min_set;
            vel_next = vel_grav;
            if (bus.duck) begin
              if (vel_grav < V_FAST) vel_next = V_FAST;
            end else if (min_set && (!bus.jump || y_reg <= MAX_Y) && vel_grav < V_DROP) begin
              vel_next = V_DROP;
            end
          end
        end
        CRASHED: begin
          if (jump_edge) begin
            state_next = RUNNING;
            y_next     = GROUND_Y12;
            vel_next   = 10'sd0;
            acc_next   = 5'd0;
            min_next   = 1'b0;
          end
        end
        default: state_next = WAITING;
      endcase
    end

    // Animation restarts whenever the state changes, else advances per tick.
    if (state_next != state_reg) begin
      anim_next = 8'd0;
    end else if (bus.update) begin
      anim_next = anim_inc;
      if ((state_reg == RUNNING || state_reg == DUCKING) && anim_inc >= RUN_WRAP) anim_next = 8'd0;
      if (state_reg == WAITING && anim_inc >= BLINK_WRAP) anim_next = 8'd0;
    end

    case (state_next)
      WAITING: frame_next = (anim_next >= BLINK_ON) ? F_WAIT1 : F_WAIT0;
      RUNNING: frame_next = (anim_next < RUN_P) ? F_RUN0 : F_RUN1;
      DUCKING: frame_next = (anim_next < RUN_P) ? F_DUCK0 : F_DUCK1;
      JUMPING: frame_next = F_JUMP0;
      default: frame_next = F_CRASH;
    endcase
  end

  // Register update with synchronous reset back to the waiting pose.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= WAITING;
      y_reg      <= GROUND_Y12;
      vel_reg    <= 10'sd0;
      acc_reg    <= 5'd0;
      min_reg    <= 1'b0;
      anim_reg   <= 8'd0;
      jump_q_reg <= 1'b0;
      frame_reg  <= F_WAIT0;
    end else begin
      state_reg  <= state_next;
      y_reg      <= y_next;
      vel_reg    <= vel_next;
      acc_reg    <= acc_next;
      min_reg    <= min_next;
      anim_reg   <= anim_next;
      jump_q_reg <= jump_q_next;
      frame_reg  <= frame_next;
    end
  end

  assign bus.x_pos  = 12'(START_X);
  assign bus.y_pos  = y_reg;
  assign bus.state  = state_reg;
  assign bus.frame  = frame_reg;
  assign bus.width  = (state_reg == DUCKING) ? 10'(WIDTH_DUCK) : 10'(WIDTH);
  assign bus.height = (state_reg == DUCKING) ? 10'(HEIGHT_DUCK) : 10'(HEIGHT);

endmodule

// File: tb/tb_runner_char.sv
// Self-checking bench for runner_char: directed scenarios followed by random
// play, every tick compared against a plain-integer model of the game rules.
module tb_runner_char;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  runner_char_if #(.SPEED_W(5)) bus ();

  runner_char dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: state 0..4, frame 0..7, plain integers.
  int m_state, m_y, m_vel, m_acc, m_anim, m_frame;
  bit m_min, m_jq;

  function automatic int frame_of(input int st, input int an);
    case (st)
      0: return (an >= 54) ? 0 + 1 : 0;
      1: return (an < 5) ? 2 : 3;
      3: return (an < 5) ? 5 : 6;
      2: return 4;
      default: return 7;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_y = 93; m_vel = 0; m_acc = 0; m_anim = 0;
    m_min = 0; m_jq = 0; m_frame = 0;
  endtask

  task automatic model_step(input bit u, input int spd, input bit j, input bit d, input bit c);
    int ns;
    int old_y;
    bit edge_j;
    ns = m_state;
    edge_j = j && !m_jq;
    if (c && (m_state >= 1 && m_state <= 3)) begin
      ns = 4;
    end else if (u) begin
      case (m_state)
        0: if (edge_j) ns = 1;
        1: begin
          if (j) begin
            ns = 2; m_vel = -10 - spd / 8; m_acc = 0; m_min = 0;
          end else if (d) ns = 3;
        end
        3: if (!d) ns = 1;
        2: begin
          if (m_y + m_vel >= 93) begin
            ns = d ? 3 : 1; m_y = 93; m_vel = 0; m_acc = 0;
          end else begin
            old_y = m_y;
            m_y = m_y + m_vel;
            m_acc = m_acc + 6;
            if (m_acc >= 10) begin m_acc = m_acc - 10; m_vel = m_vel + 1; end
            if (old_y <= 63) m_min = 1;
            if (d) begin
              if (m_vel < 12) m_vel = 12;
            end else if (m_min && (!j || old_y <= 30) && m_vel < -5) m_vel = -5;
          end
        end
        default: begin
          if (edge_j) begin
            ns = 1; m_y = 93; m_vel = 0; m_acc = 0; m_min = 0;
          end
        end
      endcase
      m_jq = j;
    end
    if (ns != m_state) m_anim = 0;
    else if (u) begin
      m_anim = (m_anim + 1) % 256;
      if ((m_state == 1 || m_state == 3) && m_anim >= 10) m_anim = 0;
      if (m_state == 0 && m_anim >= 60) m_anim = 0;
    end
    m_state = ns;
    m_frame = frame_of(m_state, m_anim);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  int'(bus.state), m_state);
    chk({tag, ".frame"},  int'(bus.frame), m_frame);
    chk({tag, ".y"},      int'(bus.y_pos), m_y);
    chk({tag, ".x"},      int'(bus.x_pos), 50);
    chk({tag, ".width"},  int'(bus.width), (m_state == 3) ? 59 : 44);
    chk({tag, ".height"}, int'(bus.height), (m_state == 3) ? 25 : 47);
  endtask

  task automatic tick(input string tag, input bit u, input int spd, input bit j, input bit d, input bit c);
    @(negedge clk);
    bus.update = u; bus.speed = 5'(spd); bus.jump = j; bus.duck = d; bus.crash = c;
    model_step(u, spd, j, d, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.update = 0; bus.speed = 0; bus.jump = 0; bus.duck = 0; bus.crash = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_all("reset");
  endtask

  initial begin
    int guard;
    int y0;
    bit rj, rd, ru, rc;
    int rs;

    // Reset, then jump held without ticks: nothing may move.
    do_reset();
    for (int i = 0; i < 3; i++) tick("hold_no_update", 0, 0, 1, 0, 0);
    chk("hold.state", int'(bus.state), 0);
    tick("first_update", 1, 0, 1, 0, 0);
    chk("first_update.state", int'(bus.state), 1);
    chk("first_update.frame", int'(bus.frame), 2);

    // Speed 6 jump with jump held, then release after the minimum height.
    tick("takeoff6", 1, 6, 1, 0, 0);
    chk("takeoff6.state", int'(bus.state), 2);
    chk("takeoff6.y", int'(bus.y_pos), 93);
    tick("rise6", 1, 6, 1, 0, 0);
    chk("rise6.y1", int'(bus.y_pos), 83);
    tick("rise6", 1, 6, 1, 0, 0);
    chk("rise6.y2", int'(bus.y_pos), 73);
    tick("rise6", 1, 6, 1, 0, 0);
    chk("rise6.y3", int'(bus.y_pos), 64);
    guard = 0;
    while (m_y > 63 && guard < 50) begin tick("rise6_more", 1, 6, 1, 0, 0); guard++; end
    tick("release6", 1, 6, 0, 0, 0);
    guard = 0;
    while (m_state == 2 && guard < 100) begin tick("fall6", 1, 6, 0, 0, 0); guard++; end
    chk("land6.state", int'(bus.state), 1);
    chk("land6.y", int'(bus.y_pos), 93);

    // Speed 31 jump held to the apex: max-height cut-off applies.
    tick("takeoff31", 1, 31, 1, 0, 0);
    guard = 0;
    while (m_state == 2 && guard < 100) begin tick("arc31", 1, 31, 1, 0, 0); guard++; end
    chk("land31.state", int'(bus.state), 1);

    // Mid-air duck at vel -8, held through landing.
    tick("pre_duck_jump", 1, 0, 0, 0, 0);
    tick("takeoff0", 1, 0, 1, 0, 0);
    guard = 0;
    while (m_vel != -8 && m_state == 2 && guard < 50) begin tick("rise0", 1, 0, 1, 0, 0); guard++; end
    tick("duck_air", 1, 0, 1, 1, 0);
    y0 = int'(bus.y_pos);
    tick("fast_drop", 1, 0, 1, 1, 0);
    if (m_state == 2) chk("fast_drop.dy", int'(bus.y_pos) - y0, 12);
    guard = 0;
    while (m_state == 2 && guard < 50) begin tick("drop", 1, 0, 1, 1, 0); guard++; end
    chk("duck_land.state", int'(bus.state), 3);
    chk("duck_land.width", int'(bus.width), 59);
    chk("duck_land.height", int'(bus.height), 25);
    chk("duck_land.y", int'(bus.y_pos), 93);
    tick("unduck", 1, 0, 0, 0, 0);

    // Crash pulse without a tick during a jump, then restart via a jump edge.
    tick("takeoff_c", 1, 8, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick("rise_c", 1, 8, 1, 0, 0);
    y0 = int'(bus.y_pos);
    tick("crash", 0, 8, 1, 0, 1);
    chk("crash.state", int'(bus.state), 4);
    chk("crash.frame", int'(bus.frame), 7);
    chk("crash.y_frozen", int'(bus.y_pos), y0);
    for (int i = 0; i < 3; i++) tick("crash_hold_jump", 1, 8, 1, 0, 0);
    chk("crash_hold.state", int'(bus.state), 4);
    tick("crash_release", 1, 8, 0, 0, 0);
    tick("restart", 1, 8, 1, 0, 0);
    chk("restart.state", int'(bus.state), 1);
    chk("restart.y", int'(bus.y_pos), 93);

    // Waiting blink cycle over two periods.
    do_reset();
    for (int k = 1; k <= 130; k++) begin
      tick("blink", 1, 0, 0, 0, 0);
      chk("blink.frame_k", int'(bus.frame), ((k % 60) >= 54) ? 1 : 0);
    end

    // Running animation: 5 ticks of frame 2, then 5 of frame 3.
    tick("start_run", 1, 0, 1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      tick("run_anim", 1, 0, 0, 0, 0);
      chk("run_anim.frame_k", int'(bus.frame), ((k % 10) < 5) ? 2 : 3);
    end

    // Random play against the model.
    rj = 0; rd = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) rj = ~rj;
      if ($urandom_range(0, 7) == 0) rd = ~rd;
      ru = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 39) == 0);
      rs = int'($urandom_range(0, 31));
      tick("rand", ru, rs, rj, rd, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
